// File: rtl/rv_bus_pkg.sv
// Shared types and bus encodings for the memory target on the CPU bus.
package rv_bus_pkg;

  // Prefixed so these never collide with the bus unit's own state enum.
  typedef enum logic [1:0] {
    MT_IDLE,
    MT_WAIT,
    MT_ACK
  } mem_state_t;

  localparam logic BUS_RD    = 1'b1;
  localparam logic BUS_WR    = 1'b0;
  localparam logic BUS_INSTR = 1'b1;
  localparam logic BUS_DATA  = 1'b0;

endpackage

// File: rtl/rv_mem_sram_1rw.sv
// Single-port word array with per-byte write enables and a registered read port.
module rv_mem_sram_1rw #(
  parameter int    DEPTH_WORDS = 1024,
  parameter int    AW          = 10,
  parameter string INIT_FILE   = ""
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Read returns the pre-write contents when a read and a write hit the same edge.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (we[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/rv_bus_mem.sv
// Memory target on the single-master CPU bus: decodes ads commands, inserts
// instruction/data wait states and returns a one-cycle ack with read data.
module rv_bus_mem
  import rv_bus_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          IWAIT       = 1,
  parameter int          DWAIT       = 2,
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ads,
  input  logic        rd_wr_n,
  input  logic        i_dn,
  input  logic [31:0] addr,
  input  logic [3:0]  be,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        ack,
  output logic        bus_err,
  output logic        proto_err
);

  localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH32 = 32'(DEPTH_WORDS);
  localparam logic [3:0]  IW4     = 4'(IWAIT);
  localparam logic [3:0]  DW4     = 4'(DWAIT);

  mem_state_t    state;
  logic [3:0]    wait_cnt;
  logic          cmd_rd;
  logic          cmd_ok;
  logic [AW-1:0] cmd_idx;
  logic [3:0]    cmd_be;
  logic [31:0]   cmd_wdata;

  logic [31:0]   word_off;
  logic          live_ok;
  logic [AW-1:0] live_idx;
  logic [3:0]    load_w;
  logic [AW-1:0] sram_addr;
  logic [3:0]    sram_we;
  logic [31:0]   sram_q;

  assign word_off = (addr - BASE_ADDR) >> 2;
  assign live_ok  = (addr >= BASE_ADDR) && (word_off < DEPTH32);
  assign live_idx = word_off[AW-1:0];
  assign load_w   = (i_dn == BUS_INSTR) ? IW4 : DW4;

  // While idle the array reads the live bus address so a zero-wait read has
  // its data ready in the very next cycle; afterwards it holds the latched index.
  assign sram_addr = (state == MT_IDLE) ? live_idx : cmd_idx;
  assign sram_we   = (state == MT_ACK && cmd_rd == BUS_WR && cmd_ok) ? cmd_be : 4'b0000;

  rv_mem_sram_1rw #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW),
    .INIT_FILE   (INIT_FILE)
  ) u_sram (
    .clk   (clk),
    .we    (sram_we),
    .addr  (sram_addr),
    .wdata (cmd_wdata),
    .rdata (sram_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= MT_IDLE;
      ack       <= 1'b0;
      wait_cnt  <= 4'd0;
      cmd_rd    <= 1'b0;
      cmd_ok    <= 1'b0;
      cmd_idx   <= '0;
      cmd_be    <= 4'b0000;
      cmd_wdata <= 32'd0;
      bus_err   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      ack <= 1'b0;
      if (ads && state != MT_IDLE) proto_err <= 1'b1;
      case (state)
        MT_IDLE: begin
          if (ads) begin
            cmd_rd    <= rd_wr_n;
            cmd_ok    <= live_ok;
            cmd_idx   <= live_idx;
            cmd_be    <= be;
            cmd_wdata <= wr_data;
            wait_cnt  <= load_w;
            if (!live_ok) bus_err <= 1'b1;
            if (load_w == 4'd0) begin
              state <= MT_ACK;
              ack   <= 1'b1;
            end else begin
              state <= MT_WAIT;
            end
          end
        end
        MT_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            state <= MT_ACK;
            ack   <= 1'b1;
          end
        end
        MT_ACK:  state <= MT_IDLE;
        default: state <= MT_IDLE;
      endcase
    end
  end

  // Array output and the select flags are all flops, so rd_data moves with ack.
  always_comb begin
    rd_data = 32'd0;
    if (ack && cmd_rd == BUS_RD) rd_data = cmd_ok ? sram_q : ERR_DATA;
  end

endmodule
